// File: rtl/time_encoder.sv
// time_encoder: converts BCD time HH:MM:SS.CC into a clock-cycle count
// (total centiseconds * TICKS_PER_CS) using digit accumulation followed by
// a bit-serial shift-and-add against the constant.
//
// state | meaning
// IDLE  | waiting for start; digits latched on accept
// CHECK | range-check latched digits
// ACC   | fold 8 digits MSD-first into acc (mixed radix 10/6)
// SCALE | shift-and-add acc by TICKS_PER_CS, one constant bit per cycle
// DONE  | pulse done (and err on bad digits); load cnt on success
module time_encoder #(
    parameter int unsigned TICKS_PER_CS = 100000,
    parameter int unsigned MULT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  h1,
    input  logic [3:0]  h0,
    input  logic [3:0]  m1,
    input  logic [3:0]  m0,
    input  logic [3:0]  s1,
    input  logic [3:0]  s0,
    input  logic [3:0]  cs1,
    input  logic [3:0]  cs0,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] cnt
);

    localparam int unsigned CW = $clog2(MULT_W + 1);
    localparam logic [MULT_W-1:0] TICKS_VEC = MULT_W'(TICKS_PER_CS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ACC   = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [31:0]        digs;      // {h1,h0,m1,m0,s1,s0,cs1,cs0}, shifted left during ACC
    logic [24:0]        acc;
    logic [63:0]        product;
    logic [63:0]        mcand;     // acc shifted left once per SCALE step
    logic [MULT_W-1:0]  mult;      // remaining constant bits, LSB is current
    logic [CW-1:0]      tmr;       // down-counter, phase ends at zero
    logic               bad;

    logic               range_bad;
    logic [24:0]        acc_scaled;
    logic [24:0]        acc_next;

    // Digit range check on the latched digits (tens of h/m/s max 5, others max 9)
    always_comb begin
        range_bad = (digs[31:28] > 4'd5) || (digs[27:24] > 4'd9) ||
                    (digs[23:20] > 4'd5) || (digs[19:16] > 4'd9) ||
                    (digs[15:12] > 4'd5) || (digs[11:8]  > 4'd9) ||
                    (digs[7:4]   > 4'd9) || (digs[3:0]   > 4'd9);
    end

    // Next accumulator value: *6 before a tens-of-minutes/seconds digit, *10 otherwise.
    // The first step multiplies a cleared acc, so it simply loads h1.
    always_comb begin
        acc_scaled = 25'd0;
        if (tmr == CW'(5) || tmr == CW'(3)) begin
            acc_scaled = (acc << 2) + (acc << 1);
        end else begin
            acc_scaled = (acc << 3) + (acc << 1);
        end
        acc_next = acc_scaled + {21'd0, digs[31:28]};
    end

    // Conversion FSM with registered handshake outputs and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            digs    <= '0;
            acc     <= '0;
            product <= '0;
            mcand   <= '0;
            mult    <= '0;
            tmr     <= '0;
            bad     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        digs    <= {h1, h0, m1, m0, s1, s0, cs1, cs0};
                        acc     <= '0;
                        product <= '0;
                        bad     <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    bad <= range_bad;
                    if (range_bad) begin
                        state <= DONE;
                    end else begin
                        tmr   <= CW'(7);
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc  <= acc_next;
                    digs <= {digs[27:0], 4'd0};
                    if (tmr == '0) begin
                        mcand <= {39'd0, acc_next};
                        mult  <= TICKS_VEC;
                        tmr   <= CW'(MULT_W - 1);
                        state <= SCALE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                SCALE: begin
                    if (mult[0]) begin
                        product <= product + mcand;
                    end
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    if (tmr == '0) begin
                        state <= DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    err  <= bad;
                    if (!bad) begin
                        cnt <= product;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_encoder.sv
// tb_time_encoder: directed and randomized checks of time_encoder against
// an arithmetic reference (total centiseconds * 100000).
module tb_time_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] digits;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] cnt;

    int n_checks;
    int n_fail;
    logic [63:0] model_cnt;

    time_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .h1    (digits[31:28]),
        .h0    (digits[27:24]),
        .m1    (digits[23:20]),
        .m0    (digits[19:16]),
        .s1    (digits[15:12]),
        .s0    (digits[11:8]),
        .cs1   (digits[7:4]),
        .cs0   (digits[3:0]),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dg(input logic [31:0] d, input int pos);
        return int'((d >> (4 * pos)) & 32'hF);
    endfunction

    // pos 7..0 = h1,h0,m1,m0,s1,s0,cs1,cs0
    function automatic bit legal(input logic [31:0] d);
        return dg(d, 7) <= 5 && dg(d, 6) <= 9 && dg(d, 5) <= 5 && dg(d, 4) <= 9 &&
               dg(d, 3) <= 5 && dg(d, 2) <= 9 && dg(d, 1) <= 9 && dg(d, 0) <= 9;
    endfunction

    function automatic logic [63:0] ref_cnt(input logic [31:0] d);
        longint unsigned hrs, mins, secs, cents;
        hrs   = longint'(dg(d, 7) * 10 + dg(d, 6));
        mins  = longint'(dg(d, 5) * 10 + dg(d, 4));
        secs  = longint'(dg(d, 3) * 10 + dg(d, 2));
        cents = longint'(dg(d, 1) * 10 + dg(d, 0));
        return 64'((hrs * 360000 + mins * 6000 + secs * 100 + cents) * 100000);
    endfunction

    task automatic run_conv(input logic [31:0] d, input string tag);
        int k;
        bit seen;
        int exp_lat;
        digits = d;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            tick();
            k++;
            if (done) seen = 1'b1;
        end
        exp_lat = legal(d) ? 27 : 2;
        if (legal(d)) model_cnt = ref_cnt(d);
        chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        chk({tag, "_err"}, 64'(err), 64'(!legal(d)));
        chk({tag, "_cnt"}, cnt, model_cnt);
        tick();
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rand_digits();
        logic [31:0] d;
        for (int p = 0; p < 8; p++) begin
            int lim;
            int v;
            lim = (p == 7 || p == 5 || p == 3) ? 5 : 9;
            if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 15));
            else v = int'($urandom_range(0, lim));
            d[4*p +: 4] = 4'(v);
        end
        return d;
    endfunction

    initial begin
        int ndone;
        int first_done;
        int second_done;
        n_checks  = 0;
        n_fail    = 0;
        model_cnt = 64'd0;
        rst    = 1'b1;
        start  = 1'b0;
        digits = 32'h0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt", cnt, 64'd0);
        rst = 1'b0;
        tick();

        run_conv(32'h00000001, "one_cs");
        run_conv(32'h59595999, "max");
        run_conv(32'h12345678, "mid");
        run_conv(32'h12346678, "bad_s1");
        run_conv(32'h1234567A, "bad_cs0");
        run_conv(32'h60000000, "bad_h1");
        run_conv(32'h00000000, "zero");

        // Async reset mid-conversion, mid-cycle
        run_conv(32'h23595999, "pre_rst");
        digits = 32'h01020304;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_err", 64'(err), 64'd0);
        chk("async_cnt", cnt, 64'd0);
        model_cnt = 64'd0;
        tick();
        rst = 1'b0;
        tick();

        // Start pulses while busy are ignored; digit changes after accept have no effect
        run_conv(32'h01000000, "seed");
        digits = 32'h12345678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        first_done = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 3) digits = 32'h00000005;
            start = (k == 5 || k == 20);
            tick();
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
        end
        start = 1'b0;
        model_cnt = ref_cnt(32'h12345678);
        chk("ignore_ndone", 64'(ndone), 64'd1);
        chk("ignore_lat", 64'(first_done), 64'd27);
        chk("latched_cnt", cnt, model_cnt);

        // start held high: back-to-back conversions every 28 cycles
        digits = 32'h00001234;
        start  = 1'b1;
        tick();
        ndone = 0;
        first_done = 0;
        second_done = 0;
        for (int k = 1; k <= 70; k++) begin
            start = (k <= 28);
            tick();
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
                else second_done = k;
            end
        end
        start = 1'b0;
        model_cnt = ref_cnt(32'h00001234);
        chk("b2b_ndone", 64'(ndone), 64'd2);
        chk("b2b_first", 64'(first_done), 64'd27);
        chk("b2b_second", 64'(second_done), 64'd55);
        chk("b2b_cnt", cnt, model_cnt);

        // Reset at cycle 10 of a conversion: no done, cnt cleared, then normal operation
        digits = 32'h05050505;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        rst = 1'b1;
        #1;
        model_cnt = 64'd0;
        chk("abort_cnt", cnt, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_nodone", 64'(ndone), 64'd0);
        chk("abort_cnt_hold", cnt, 64'd0);
        run_conv(32'h10203040, "post_rst");

        for (int i = 0; i < 25; i++) begin
            run_conv(rand_digits(), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
